// File: rtl/id_stage.sv
// id_stage: RV32I-subset decode stage (R-ALU, I-ALU, LW, SW, BEQ).
// Holds the 32-entry register file, detects load-use hazards and drives the
// registered ID/EX pipeline register feeding EX.
// Optional build macro: RF_WB_BYPASS_EN. When defined, a write-back landing in
// the same cycle as an operand read is forwarded into the captured operand.
module id_stage #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] PC,
  input  logic             if_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             hazard_stall,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_rs1_data,
  output logic [WIDTH-1:0] ex_rs2_data,
  output logic [WIDTH-1:0] ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_illegal
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLL = 4'd5,
                         ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8,
                         ALU_SLTU = 4'd9;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [3:0]       alu_op;
    logic             alu_src;
    logic             branch;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             illegal;
  } idex_t;

  // funct3 (plus the funct7[5] alternate bit) to ALU operation
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] imm_i(input logic [31:0] i);
    return {{(WIDTH-12){i[31]}}, i[31:20]};
  endfunction

  function automatic logic signed [WIDTH-1:0] imm_s(input logic [31:0] i);
    return {{(WIDTH-12){i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic signed [WIDTH-1:0] imm_b(input logic [31:0] i);
    return {{(WIDTH-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  logic [WIDTH-1:0] rf [NREGS];
  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic [4:0]       rs1, rs2, rd;
  logic [WIDTH-1:0] rd1, rd2;
  logic             rs2_used, legal;
  idex_t            dec_p0, idex_p1;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  // Register file: cleared on reset, x0 never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Combinational operand read, optionally forwarding a same-cycle write-back
  always_comb begin
    rd1 = (rs1 == 5'd0) ? '0 : rf[rs1];
    rd2 = (rs2 == 5'd0) ? '0 : rf[rs2];
`ifdef RF_WB_BYPASS_EN
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs1) rd1 = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs2) rd2 = wb_data;
`endif
  end

  // Decode into the next ID/EX contents; unused indices/operands are zeroed
  always_comb begin
    dec_p0          = '0;
    rs2_used        = 1'b0;
    legal           = 1'b0;
    dec_p0.valid    = 1'b1;
    dec_p0.pc       = PC;
    dec_p0.rs1      = rs1;
    dec_p0.rs1_data = rd1;
    case (opcode)
      OP_R: begin
        legal = (funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        dec_p0.alu_op    = alu_map(funct3, funct7[5]);
        dec_p0.reg_write = 1'b1;
        rs2_used         = 1'b1;
      end
      OP_I: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       legal = 1'b1;
        dec_p0.alu_op    = alu_map(funct3, (funct3 == 3'b101) && funct7[5]);
        dec_p0.alu_src   = 1'b1;
        dec_p0.reg_write = 1'b1;
        dec_p0.imm       = imm_i(instruction);
      end
      OP_LW: begin
        legal             = (funct3 == 3'b010);
        dec_p0.alu_src    = 1'b1;
        dec_p0.mem_read   = 1'b1;
        dec_p0.mem_to_reg = 1'b1;
        dec_p0.reg_write  = 1'b1;
        dec_p0.imm        = imm_i(instruction);
      end
      OP_SW: begin
        legal            = (funct3 == 3'b010);
        dec_p0.alu_src   = 1'b1;
        dec_p0.mem_write = 1'b1;
        dec_p0.imm       = imm_s(instruction);
        rs2_used         = 1'b1;
      end
      OP_B: begin
        legal         = (funct3 == 3'b000);
        dec_p0.alu_op = ALU_SUB;
        dec_p0.branch = 1'b1;
        dec_p0.imm    = imm_b(instruction);
        rs2_used      = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (rs2_used) begin
      dec_p0.rs2      = rs2;
      dec_p0.rs2_data = rd2;
    end
    if (dec_p0.reg_write) dec_p0.rd = rd;
    if (!legal) begin
      dec_p0         = '0;
      dec_p0.valid   = 1'b1;
      dec_p0.pc      = PC;
      dec_p0.illegal = 1'b1;
      rs2_used       = 1'b0;
    end
  end

  assign hazard_stall = !flush && if_valid && idex_p1.valid && idex_p1.mem_read &&
                        (idex_p1.rd != 5'd0) &&
                        ((idex_p1.rd == rs1) || (idex_p1.rd == rs2 && rs2_used));

  // ---- ID/EX boundary: flush > stall > hazard/empty bubble > load ----
  always_ff @(posedge clk) begin
    if (rst || flush)                 idex_p1 <= '0;
    else if (stall)                   idex_p1 <= idex_p1;
    else if (hazard_stall || !if_valid) idex_p1 <= '0;
    else                              idex_p1 <= dec_p0;
  end

  assign ex_valid      = idex_p1.valid;
  assign ex_pc         = idex_p1.pc;
  assign ex_rs1_data   = idex_p1.rs1_data;
  assign ex_rs2_data   = idex_p1.rs2_data;
  assign ex_imm        = idex_p1.imm;
  assign ex_rs1        = idex_p1.rs1;
  assign ex_rs2        = idex_p1.rs2;
  assign ex_rd         = idex_p1.rd;
  assign ex_alu_op     = idex_p1.alu_op;
  assign ex_alu_src    = idex_p1.alu_src;
  assign ex_branch     = idex_p1.branch;
  assign ex_mem_read   = idex_p1.mem_read;
  assign ex_mem_write  = idex_p1.mem_write;
  assign ex_reg_write  = idex_p1.reg_write;
  assign ex_mem_to_reg = idex_p1.mem_to_reg;
  assign ex_illegal    = idex_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed bench for id_stage with an expected-result queue.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, stall, flush, wb_we;
  logic [31:0] instruction, PC, wb_data;
  logic [4:0]  wb_rd;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_branch, ex_mem_read, ex_mem_write;
  logic        ex_reg_write, ex_mem_to_reg, ex_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        partial;
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        src, br, mr, mw, rw, m2r, ill;
  } exp_t;

  exp_t sb[$];

  id_stage #(.WIDTH(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .PC(PC),
    .if_valid(if_valid), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic exp_t r_exp(input logic [31:0] pc, input logic [4:0] s1, s2, d,
                                 input logic [31:0] v1, v2, input logic [3:0] op);
    exp_t e = '0;
    e.valid = 1'b1; e.pc = pc; e.rs1 = s1; e.rs2 = s2; e.rd = d;
    e.d1 = v1; e.d2 = v2; e.op = op; e.rw = 1'b1;
    return e;
  endfunction

  // Push the expectation, clock once, then pop and compare against ID/EX
  task automatic tick(input exp_t e, input string name);
    exp_t g;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({name, ".valid"}, 32'(ex_valid), 32'(g.valid));
    chk({name, ".pc"}, ex_pc, g.pc);
    chk({name, ".illegal"}, 32'(ex_illegal), 32'(g.ill));
    chk({name, ".ctl"}, {27'd0, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg},
        {27'd0, g.br, g.mr, g.mw, g.rw, g.m2r});
    if (!g.partial) begin
      chk({name, ".rs1_data"}, ex_rs1_data, g.d1);
      chk({name, ".rs2_data"}, ex_rs2_data, g.d2);
      chk({name, ".imm"}, ex_imm, g.imm);
      chk({name, ".idx"}, {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, g.rs1, g.rs2, g.rd});
      chk({name, ".alu_op"}, 32'(ex_alu_op), 32'(g.op));
      chk({name, ".alu_src"}, 32'(ex_alu_src), 32'(g.src));
    end
  endtask

  initial begin
    exp_t z, e;
    z = '0;
    rst = 1'b1; if_valid = 1'b1; instruction = 32'h000281B3; PC = 32'h0;
    stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;

    // Reset for two cycles with a valid instruction presented
    tick(z, "reset0");
    tick(z, "reset1");
    chk("reset.hazard", 32'(hazard_stall), 32'd0);
    rst = 1'b0;

    // Every register reads zero after reset
    for (int i = 1; i < 32; i++) begin
      instruction = {7'd0, 5'(i), 5'(i), 3'b000, 5'd3, 7'b0110011};
      PC = 32'(i * 4);
      tick(r_exp(PC, 5'(i), 5'(i), 5'd3, 32'd0, 32'd0, 4'd0), "rf_zero");
    end

    // Write x5, then read it on the next cycle
    if_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    tick(z, "wb_x5");
    wb_we = 1'b0; if_valid = 1'b1; instruction = 32'h000281B3; PC = 32'h100;
    tick(r_exp(32'h100, 5'd5, 5'd0, 5'd3, 32'hDEADBEEF, 32'd0, 4'd0), "wr_then_rd");

    // Same-cycle write and read of x5
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h11111111; PC = 32'h104;
`ifdef RF_WB_BYPASS_EN
    tick(r_exp(32'h104, 5'd5, 5'd0, 5'd3, 32'h11111111, 32'd0, 4'd0), "same_cycle");
`else
    tick(r_exp(32'h104, 5'd5, 5'd0, 5'd3, 32'hDEADBEEF, 32'd0, 4'd0), "same_cycle");
`endif

    // Write to x0 is discarded
    if_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h1234;
    tick(z, "wb_x0");
    wb_we = 1'b0; if_valid = 1'b1; instruction = 32'h000001B3; PC = 32'h108;
    tick(r_exp(32'h108, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 4'd0), "read_x0");

    // Load-use: lw x2,8(x1) then add x4,x2,x3
    instruction = 32'h0080A103; PC = 32'h200;
    #1 chk("lw.hazard", 32'(hazard_stall), 32'd0);
    e = '0; e.valid = 1'b1; e.pc = 32'h200; e.rs1 = 5'd1; e.rd = 5'd2; e.imm = 32'd8;
    e.src = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1;
    tick(e, "lw");
    instruction = 32'h00310233; PC = 32'h204;
    #1 chk("loaduse.hazard_on", 32'(hazard_stall), 32'd1);
    tick(z, "loaduse.bubble");
    chk("loaduse.hazard_off", 32'(hazard_stall), 32'd0);
    tick(r_exp(32'h204, 5'd2, 5'd3, 5'd4, 32'd0, 32'd0, 4'd0), "loaduse.add");

    // Store with negative offset: sw x2,-4(x1)
    instruction = 32'hFE20AE23; PC = 32'h208;
    e = '0; e.valid = 1'b1; e.pc = 32'h208; e.rs1 = 5'd1; e.rs2 = 5'd2;
    e.imm = 32'hFFFFFFFC; e.src = 1'b1; e.mw = 1'b1;
    tick(e, "sw");

    // srai x6,x5,3 (x5 now holds the same-cycle write)
    instruction = 32'h4032D313; PC = 32'h20C;
    e = '0; e.valid = 1'b1; e.pc = 32'h20C; e.rs1 = 5'd5; e.rd = 5'd6; e.d1 = 32'h11111111;
    e.imm = 32'h403; e.op = 4'd7; e.src = 1'b1; e.rw = 1'b1;
    tick(e, "srai");

    // beq x1,x2,+16
    instruction = 32'h00208863; PC = 32'h210;
    e = '0; e.valid = 1'b1; e.pc = 32'h210; e.rs1 = 5'd1; e.rs2 = 5'd2;
    e.imm = 32'd16; e.op = 4'd1; e.br = 1'b1;
    tick(e, "beq");

    // Flush wins over stall and suppresses the load-use hazard
    instruction = 32'h0080A103; PC = 32'h300;
    e = '0; e.valid = 1'b1; e.pc = 32'h300; e.rs1 = 5'd1; e.rd = 5'd2; e.imm = 32'd8;
    e.src = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1;
    tick(e, "lw2");
    instruction = 32'h00310233; PC = 32'h304; flush = 1'b1; stall = 1'b1;
    #1 chk("flush.hazard_forced", 32'(hazard_stall), 32'd0);
    tick(z, "flush_stall.add");
    instruction = 32'h0080A103; PC = 32'h308;
    tick(z, "flush_stall.lw");
    chk("flush.hazard_after", 32'(hazard_stall), 32'd0);
    flush = 1'b0; stall = 1'b0;

    // Stall holds ID/EX while write-back still lands
    instruction = 32'hFE20AE23; PC = 32'h400;
    e = '0; e.valid = 1'b1; e.pc = 32'h400; e.rs1 = 5'd1; e.rs2 = 5'd2;
    e.imm = 32'hFFFFFFFC; e.src = 1'b1; e.mw = 1'b1;
    tick(e, "sw2");
    stall = 1'b1; instruction = 32'h4032D313; PC = 32'h404;
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFEF00D;
    tick(e, "stall_hold");
    stall = 1'b0; wb_we = 1'b0; instruction = 32'h00038433; PC = 32'h408;
    tick(r_exp(32'h408, 5'd7, 5'd0, 5'd8, 32'hCAFEF00D, 32'd0, 4'd0), "wb_during_stall");

    // Unsupported opcode
    instruction = 32'h0000007F; PC = 32'h500;
    e = '0; e.partial = 1'b1; e.valid = 1'b1; e.pc = 32'h500; e.ill = 1'b1;
    tick(e, "illegal");

    // Reset mid-operation clears ID/EX and register file on the same edge
    rst = 1'b1; wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h5;
    instruction = 32'h00038433; PC = 32'h600;
    tick(z, "mid_reset");
    rst = 1'b0; wb_we = 1'b0; instruction = 32'h007481B3; PC = 32'h604;
    tick(r_exp(32'h604, 5'd9, 5'd7, 5'd3, 32'd0, 32'd0, 4'd0), "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
